// File: rtl/icache_pkg.sv
// Package: icache_pkg
// Shared definitions for the instruction cache: FSM state encoding, the NOP
// word returned when no fetch is requested, and address-split width helpers.
// Optional feature macro used by the top: ICACHE_STATS_EN.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FILL   = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int num_lines, input int line_words);
    return 32 - idx_w(num_lines) - off_w(line_words);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Module: icache_data_array
// Instruction data storage, NUM_LINES*LINE_WORDS words of 32 bits.
// No reset; contents are only meaningful for lines the top marks valid.
// Ports:
//   clk_i      clock
//   we_i       write enable (one refill beat)
//   wr_line_i  line index written
//   wr_word_i  word within line written
//   wr_data_i  refill word
//   rd_line_i  line index read (combinational)
//   rd_word_i  word within line read (combinational)
//   rd_data_o  read word
module icache_data_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [idx_w(NUM_LINES)-1:0]  wr_line_i,
  input  logic [off_w(LINE_WORDS)-3:0] wr_word_i,
  input  logic [31:0]                  wr_data_i,
  input  logic [idx_w(NUM_LINES)-1:0]  rd_line_i,
  input  logic [off_w(LINE_WORDS)-3:0] rd_word_i,
  output logic [31:0]                  rd_data_o
);

  localparam int AW = idx_w(NUM_LINES) + off_w(LINE_WORDS) - 2;

  logic [31:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[{wr_line_i, wr_word_i}] <= wr_data_i;
  end

  assign rd_data_o = mem_q[{rd_line_i, rd_word_i}];

endmodule

// File: rtl/instr_cache.sv
// Module: instr_cache
// Direct-mapped read-only instruction cache. Hits answer in the same cycle;
// a miss stalls the cpu while the whole line is fetched word by word.
// Optional macro ICACHE_STATS_EN adds hit_cnt_o / miss_cnt_o counters.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   cpu_addr_i, cpu_rd_i    fetch address / request
//   cpu_data_o, cpu_ready_o instruction word / no-stall
//   flush_i                 invalidate all lines
//   mem_addr_o, mem_rd_o    refill word address / request
//   mem_data_i, mem_ready_i refill word / beat strobe
//   hit_cnt_o, miss_cnt_o   statistics (ICACHE_STATS_EN only)
module instr_cache
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_rd_i,
  output logic [31:0] cpu_data_o,
  output logic        cpu_ready_o,
  input  logic        flush_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_rd_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ready_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(NUM_LINES);
  localparam int TAG_W = tag_w(NUM_LINES, LINE_WORDS);
  localparam int WRD_W = OFF_W - 2;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [31-OFF_W:0]    line_q;     // line address being refilled (addr[31:OFF_W])
  logic [WRD_W-1:0]     cnt_q;
  logic                 flushed_q;  // flush arrived while a refill was in flight

  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] lk_idx;
  logic [WRD_W-1:0] lk_word;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             miss_start;
  logic             refill_we;
  logic [1:0]       unused_addr;

  assign lk_tag      = cpu_addr_i[31:IDX_W+OFF_W];
  assign lk_idx      = cpu_addr_i[IDX_W+OFF_W-1:OFF_W];
  assign lk_word     = cpu_addr_i[OFF_W-1:2];
  assign unused_addr = cpu_addr_i[1:0];
  assign fill_idx    = line_q[IDX_W-1:0];
  assign fill_tag    = line_q[31-OFF_W:IDX_W];

  assign hit        = (state_q == IDLE) && cpu_rd_i && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign miss_start = (state_q == IDLE) && (state_d == REFILL);
  assign refill_we  = (state_q == REFILL) && mem_ready_i;

  icache_data_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS)
  ) u_data (
    .clk_i    (clk_i),
    .we_i     (refill_we),
    .wr_line_i(fill_idx),
    .wr_word_i(cnt_q),
    .wr_data_i(mem_data_i),
    .rd_line_i(lk_idx),
    .rd_word_i(lk_word),
    .rd_data_o(rd_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_rd_i && !hit) state_d = REFILL;
      REFILL:  if (mem_ready_i && (cnt_q == WRD_W'(LINE_WORDS - 1))) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready_o = 1'b1;
    cpu_data_o  = NOP_INSTR;
    mem_rd_o    = 1'b0;
    mem_addr_o  = '0;
    case (state_q)
      IDLE: begin
        if (cpu_rd_i) begin
          cpu_ready_o = hit;
          if (hit) cpu_data_o = rd_data;
        end
      end
      REFILL: begin
        cpu_ready_o = 1'b0;
        mem_rd_o    = 1'b1;
        mem_addr_o  = {line_q, cnt_q, 2'b00};
      end
      default: cpu_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_q    <= '0;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
      valid_q   <= '0;
      for (int i = 0; i < NUM_LINES; i++) tag_q[i] <= '0;
    end else begin
      if (miss_start) begin
        line_q    <= cpu_addr_i[31:OFF_W];
        flushed_q <= 1'b0;
      end else if ((state_q != IDLE) && flush_i) begin
        flushed_q <= 1'b1;
      end
      // counter wraps to 0 on the last beat because it is exactly WRD_W bits
      if (refill_we) cnt_q <= cnt_q + WRD_W'(1);
      // a flush always beats the FILL valid-set
      if (flush_i) valid_q <= '0;
      else if ((state_q == FILL) && !flushed_q) valid_q[fill_idx] <= 1'b1;
      if (state_q == FILL) tag_q[fill_idx] <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit)        hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (miss_start) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_cache.sv
// Testbench for instr_cache (NUM_LINES=16, LINE_WORDS=4). The bench plays the
// instruction memory (word at address A is a fixed function of A) and keeps a
// table of which line base is resident at each index.
module tb_instr_cache;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] cpu_addr_i = '0;
  logic        cpu_rd_i = 1'b0;
  logic [31:0] cpu_data_o;
  logic        cpu_ready_o;
  logic        flush_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_rd_o;
  logic [31:0] mem_data_i = '0;
  logic        mem_ready_i = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  instr_cache dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_rd_i   (cpu_rd_i),
    .cpu_data_o (cpu_data_o),
    .cpu_ready_o(cpu_ready_o),
    .flush_i    (flush_i),
    .mem_addr_o (mem_addr_o),
    .mem_rd_o   (mem_rd_o),
    .mem_data_i (mem_data_i),
    .mem_ready_i(mem_ready_i)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  bit          res_valid [16];
  logic [31:0] res_base  [16];
  logic [31:0] addr_log  [$];
  logic [31:0] last_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h0001_0001) ^ 32'h1234_5678;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return res_valid[a[7:4]] && (res_base[a[7:4]] == {a[31:4], 4'h0});
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) res_valid[i] = 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // continuous checks on every cycle with meaningful outputs
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (cpu_rd_i && cpu_ready_o) chk("hit_data", cpu_data_o, mem_word(cpu_addr_i));
      if (!cpu_rd_i) begin
        chk("idle_ready", {31'd0, cpu_ready_o}, 32'd1);
        chk("idle_nop", cpu_data_o, 32'h0000_0013);
      end
      if (mem_rd_o) chk("refill_line", {2'b00, mem_addr_o[31:4], mem_addr_o[1:0]},
                        {2'b00, cpu_addr_i[31:4], 2'b00});
    end
  end

  // One fetch: lookup, and on a miss serve the refill beats (odd beats get a
  // gap cycle). flush_beat=N pulses flush_i together with beat N (1-based).
  task automatic fetch(input logic [31:0] a, input bit exp_hit, input int flush_beat);
    logic [31:0] base;
    bit ok;
    base = {a[31:4], 4'h0};
    @(posedge clk_i); #1;
    cpu_addr_i = a;
    cpu_rd_i   = 1'b1;
    @(negedge clk_i);
    chk("lookup_vs_table", {31'd0, cpu_ready_o}, {31'd0, exp_hit});
    chk("lookup_vs_model", {31'd0, cpu_ready_o}, {31'd0, model_hit(a)});
    if (exp_hit) begin
      chk("hit_no_mem_rd", {31'd0, mem_rd_o}, 32'd0);
      @(posedge clk_i); #1;
      cpu_rd_i = 1'b0;
      return;
    end
    for (int b = 0; b < 4; b++) begin
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk_i);
        if (mem_rd_o) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        chk("mem_rd_timeout", {31'd0, mem_rd_o}, 32'd1);
        @(posedge clk_i); #1;
        cpu_rd_i = 1'b0;
        return;
      end
      chk("mem_addr", mem_addr_o, base + 32'(4 * b));
      chk("refill_stall", {31'd0, cpu_ready_o}, 32'd0);
      addr_log.push_back(mem_addr_o);
      @(posedge clk_i); #1;
      if (b % 2 == 1) begin @(posedge clk_i); #1; end
      mem_ready_i = 1'b1;
      mem_data_i  = mem_word(base + 32'(4 * b));
      flush_i     = (b == flush_beat - 1);
      @(posedge clk_i); #1;
      mem_ready_i = 1'b0;
      flush_i     = 1'b0;
      mem_data_i  = 32'hBAD0_BAD0;
    end
    @(negedge clk_i);
    chk("fill_stall", {31'd0, cpu_ready_o}, 32'd0);
    chk("fill_mem_rd", {31'd0, mem_rd_o}, 32'd0);
    if (flush_beat != 0) begin
      model_clear();
      @(posedge clk_i); #1;
      cpu_rd_i = 1'b0;
      return;
    end
    res_valid[a[7:4]] = 1'b1;
    res_base[a[7:4]]  = base;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("refill_ready", {31'd0, cpu_ready_o}, 32'd1);
    chk("refill_data", cpu_data_o, mem_word(a));
    last_data = cpu_data_o;
    @(posedge clk_i); #1;
    cpu_rd_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    model_clear();
    // reset state
    repeat (2) @(negedge clk_i);
    chk("rst_mem_rd", {31'd0, mem_rd_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_ready", {31'd0, cpu_ready_o}, 32'd1);
    chk("rst_nop", cpu_data_o, 32'h0000_0013);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // no request: NOP regardless of address
    cpu_addr_i = 32'hFFFF_FFF0;
    @(negedge clk_i);
    chk("idle_lit_ready", {31'd0, cpu_ready_o}, 32'd1);
    chk("idle_lit_data", cpu_data_o, 32'h0000_0013);

    // cold miss, then hits within the line
    fetch(32'h0000_0100, 1'b0, 0);
    chk("cold_data_lit", last_data, 32'h1334_5778);
    chk("cold_addr0", addr_log[0], 32'h0000_0100);
    chk("cold_addr1", addr_log[1], 32'h0000_0104);
    chk("cold_addr2", addr_log[2], 32'h0000_0108);
    chk("cold_addr3", addr_log[3], 32'h0000_010C);
    fetch(32'h0000_0108, 1'b1, 0);
    fetch(32'h0000_010C, 1'b1, 0);

    // conflict on index 0
    fetch(32'h0000_0200, 1'b0, 0);
    fetch(32'h0000_0100, 1'b0, 0);
    fetch(32'h0000_0104, 1'b1, 0);
    fetch(32'h0000_1234, 1'b0, 0);

    // flush on the 2nd refill beat: line not kept, all lines gone
    fetch(32'h0000_0340, 1'b0, 2);
    fetch(32'h0000_0340, 1'b0, 0);
    fetch(32'h0000_0100, 1'b0, 0);
    fetch(32'h0000_0344, 1'b1, 0);

    // flush in IDLE: lookup that cycle still hits, next one misses
    @(posedge clk_i); #1;
    cpu_addr_i = 32'h0000_0348;
    cpu_rd_i   = 1'b1;
    flush_i    = 1'b1;
    @(negedge clk_i);
    chk("flush_idle_hit", {31'd0, cpu_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    cpu_rd_i = 1'b0;
    flush_i  = 1'b0;
    model_clear();
    fetch(32'h0000_0348, 1'b0, 0);

    // stray mem_ready outside REFILL is ignored
    @(posedge clk_i); #1;
    mem_ready_i = 1'b1;
    mem_data_i  = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    fetch(32'h0000_034C, 1'b1, 0);
    fetch(32'h0000_0340, 1'b1, 0);

    // async reset in the middle of a refill
    @(posedge clk_i); #1;
    cpu_addr_i = 32'h0000_03C0;
    cpu_rd_i   = 1'b1;
    @(negedge clk_i);
    chk("rst_case_miss", {31'd0, cpu_ready_o}, 32'd0);
    @(negedge clk_i);
    chk("rst_case_refill", {31'd0, mem_rd_o}, 32'd1);
    @(posedge clk_i); #1;
    mem_ready_i = 1'b1;
    mem_data_i  = mem_word(32'h0000_03C0);
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    #1;
    chk("rst_async_mem_rd", {31'd0, mem_rd_o}, 32'd0);
    chk("rst_async_addr", mem_addr_o, 32'd0);
    cpu_rd_i = 1'b0;
    model_clear();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    fetch(32'h0000_0340, 1'b0, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    model_clear();
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // 1 miss (plus its post-fill hit) and 2 more hits
    fetch(32'h0000_0100, 1'b0, 0);
    fetch(32'h0000_0104, 1'b1, 0);
    fetch(32'h0000_010C, 1'b1, 0);
`ifdef ICACHE_STATS_EN
    chk("stats_miss", miss_cnt_o, 32'd1);
    chk("stats_hit", hit_cnt_o, 32'd3);
`endif

    repeat (2) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
